wb_arbiter: RTL

Writeback stage directly upstream of `reg_file`; the sole driver of its write port (`a2`, `din`, `reg_wr`). Merges load results from the memory stage with ALU results from the execute stage into one register write per cycle. Performs load byte/halfword extraction and sign/zero extension, and buffers ALU results in a 2-entry FIFO while loads hold the write port. Exposes the in-flight write as a forwarding tap for decode.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/wb_fifo.sv | 38 +++
 rtl/wb_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-width, load-type and writeback-entry definitions
package riscv_pkg;
    localparam int REG_BITS = 5;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic [31:0]         data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of writeback entries with parallel rd-match squash
import riscv_pkg::*;
module wb_fifo #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    input  logic                          squash_en,
    input  logic [REG_BITS-1:0]           squash_rd,
    output wb_entry_t                     head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    wb_entry_t ents [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    assign head = ents[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) ents[i] <= '0;
        end else begin
            // squash first so a same-cycle push with a matching rd survives
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (squash_en && ents[i].rd == squash_rd) ents[i].valid <= 1'b0;
            if (push) begin
                ents[wr_ptr] <= push_entry;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges load and ALU results into one registered reg_file write per cycle
import riscv_pkg::*;
module wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [REG_BITS-1:0] alu_rd,
    input  logic [31:0]         alu_data,
    output logic                alu_ready,
    input  logic                ld_valid,
    input  logic [REG_BITS-1:0] ld_rd,
    input  logic [31:0]         ld_data,
    input  logic [1:0]          ld_off,
    input  logic [2:0]          ld_funct3,
    output logic [REG_BITS-1:0] a2,
    output logic [31:0]         din,
    output logic                reg_wr,
    output logic                fwd_valid,
    output logic [REG_BITS-1:0] fwd_rd,
    output logic [31:0]         fwd_data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [CW-1:0] count;
    wb_entry_t head, ld_entry, alu_entry, sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic empty, bypass, push, pop;
    assign empty     = count == '0;
    assign alu_ready = count < CW'(FIFO_DEPTH);
    assign ld_byte   = ld_data[{ld_off, 3'b000} +: 8];
    assign ld_half   = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    assign ld_ext    = (ld_funct3 == F3_LB)  ? {{24{ld_byte[7]}}, ld_byte} :
                       (ld_funct3 == F3_LH)  ? {{16{ld_half[15]}}, ld_half} :
                       (ld_funct3 == F3_LBU) ? {24'b0, ld_byte} :
                       (ld_funct3 == F3_LHU) ? {16'b0, ld_half} : ld_data;
    assign ld_entry  = '{valid: 1'b1, rd: ld_rd, data: ld_ext};
    assign alu_entry = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign sel       = ld_valid ? ld_entry : !empty ? head : alu_entry;
    assign bypass    = !ld_valid && empty && alu_valid;
    assign push      = alu_valid && alu_ready && !bypass;
    assign pop       = !ld_valid && !empty;
    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .push_entry(alu_entry), .pop(pop),
        .squash_en(ld_valid), .squash_rd(ld_rd), .head(head), .count(count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr <= 1'b0;
            a2     <= '0;
            din    <= '0;
        end else begin
            reg_wr <= sel.valid && sel.rd != '0;
            a2     <= sel.rd;
            din    <= sel.data;
        end
    end
    assign fwd_valid = reg_wr;
    assign fwd_rd    = a2;
    assign fwd_data  = din;
endmodule
